// File: rtl/ir_pkg.sv
// Shared IR frame definitions: byte offsets within a 32-bit frame, hold-state
// encoding and the default device address. The IR transmitter uses them too.
package ir_pkg;

   localparam int ADDR_LSB     = 24;
   localparam int ADDR_INV_LSB = 16;
   localparam int CMD_LSB      = 8;
   localparam int CMD_INV_LSB  = 0;

   localparam logic [7:0] DEFAULT_ADDR_MATCH = 8'h10;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } hold_state_t;

   // Frame builder for the transmitter: each data byte is followed by its complement
   function automatic logic [31:0] build_frame(input logic [7:0] a, input logic [7:0] c);
      return {a, ~a, c, ~c};
   endfunction

endpackage

// File: rtl/ir_frame_check.sv
// Splits a raw 32-bit IR frame into its address and command bytes and flags
// whether both inverse bytes are exact complements.
module ir_frame_check
   import ir_pkg::*;
(
   input  logic [31:0] burst,
   output logic        ok,
   output logic [7:0]  addr,
   output logic [7:0]  cmd
);

   logic [7:0] addr_inv;
   logic [7:0] cmd_inv;

   assign addr     = burst[ADDR_LSB     +: 8];
   assign addr_inv = burst[ADDR_INV_LSB +: 8];
   assign cmd      = burst[CMD_LSB      +: 8];
   assign cmd_inv  = burst[CMD_INV_LSB  +: 8];

   assign ok = (addr_inv == ~addr) && (cmd_inv == ~cmd);

endmodule

// File: rtl/ir_frame_decode.sv
// IR frame decoder: validates and filters received frames, tracks key hold and
// release, and presents decoded commands through a single-entry output buffer.
module ir_frame_decode
   import ir_pkg::*;
#(
   parameter logic [7:0] ADDR_MATCH  = DEFAULT_ADDR_MATCH,
   parameter bit         FILTER_EN   = 1'b1,
   parameter int         HOLD_CYCLES = 12_000_000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] burst,
   input  logic        burst_rdy,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd,
   output logic [7:0]  addr,
   output logic        is_repeat,
   output logic        key_release,
   output logic [7:0]  rel_cmd,
   output logic [7:0]  err_count,
   output logic        overflow
);

   localparam int         TW         = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   logic        frame_ok;
   logic [7:0]  frame_addr;
   logic [7:0]  frame_cmd;
   logic        addr_hit;
   logic        accept;
   logic        bad_frame;

   hold_state_t   state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic [7:0]    last_cmd, last_cmd_next;
   logic          release_next;
   logic [7:0]    rel_cmd_next;
   logic          repeat_now;

   ir_frame_check u_check (
      .burst (burst),
      .ok    (frame_ok),
      .addr  (frame_addr),
      .cmd   (frame_cmd)
   );

   assign addr_hit  = !FILTER_EN || (frame_addr == ADDR_MATCH);
   assign accept    = burst_rdy && frame_ok && addr_hit;
   assign bad_frame = burst_rdy && !frame_ok;

   // Hold FSM next state; a frame arriving as the timer would expire wins over expiry
   always_comb begin
      state_next    = state;
      timer_next    = timer;
      last_cmd_next = last_cmd;
      release_next  = 1'b0;
      rel_cmd_next  = rel_cmd;
      repeat_now    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next    = HELD;
               timer_next    = TIMER_LOAD;
               last_cmd_next = frame_cmd;
            end
         end
         HELD: begin
            if (accept) begin
               timer_next    = TIMER_LOAD;
               last_cmd_next = frame_cmd;
               if (frame_cmd == last_cmd) begin
                  repeat_now = 1'b1;
               end else begin
                  release_next = 1'b1;
                  rel_cmd_next = last_cmd;
               end
            end else if (timer <= TIMER_ONE) begin
               state_next   = IDLE;
               timer_next   = '0;
               release_next = 1'b1;
               rel_cmd_next = last_cmd;
            end else begin
               timer_next = timer - TIMER_ONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         last_cmd    <= '0;
         key_release <= 1'b0;
         rel_cmd     <= '0;
      end else begin
         state       <= state_next;
         timer       <= timer_next;
         last_cmd    <= last_cmd_next;
         key_release <= release_next;
         rel_cmd     <= rel_cmd_next;
      end
   end

   // Output buffer: a frame may load in the same cycle the previous one drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_valid <= 1'b0;
         cmd       <= '0;
         addr      <= '0;
         is_repeat <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         if (!cmd_valid || cmd_ready) begin
            cmd_valid <= 1'b1;
            cmd       <= frame_cmd;
            addr      <= frame_addr;
            is_repeat <= repeat_now;
         end else begin
            overflow <= 1'b1;
         end
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (bad_frame && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_ir_frame_decode.sv
// Directed bench for ir_frame_decode: a vector table for single-cycle behaviour
// plus hand-written sequences for hold expiry, saturation and reset.
module tb_ir_frame_decode;

   logic        clk;
   logic        rst;
   logic [31:0] burst;
   logic        burst_rdy;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd;
   logic [7:0]  addr;
   logic        is_repeat;
   logic        key_release;
   logic [7:0]  rel_cmd;
   logic [7:0]  err_count;
   logic        overflow;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [31:0] F01     = 32'h10EF01FE;
   localparam logic [31:0] F01_BAD = 32'h10EF01FF;
   localparam logic [31:0] F02     = 32'h10EF02FD;
   localparam logic [31:0] F03     = 32'h10EF03FC;
   localparam logic [31:0] F05     = 32'h10EF05FA;
   localparam logic [31:0] F07     = 32'h10EF07F8;
   localparam logic [31:0] F20     = 32'h20DF05FA;

   ir_frame_decode #(
      .ADDR_MATCH  (8'h10),
      .FILTER_EN   (1'b1),
      .HOLD_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .burst       (burst),
      .burst_rdy   (burst_rdy),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd         (cmd),
      .addr        (addr),
      .is_repeat   (is_repeat),
      .key_release (key_release),
      .rel_cmd     (rel_cmd),
      .err_count   (err_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] burst;
      logic        rdy;
      logic        ready;
      logic        expValid;
      logic [7:0]  expCmd;
      logic [7:0]  expAddr;
      logic        expRepeat;
      logic        expRelease;
      logic [7:0]  expRel;
      logic        expOvf;
      logic [7:0]  expErr;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive at a falling edge, let one rising edge pass, return at the next falling edge
   task automatic applyStimulus(input logic [31:0] b, input logic r, input logic rd);
      burst     = b;
      burst_rdy = r;
      cmd_ready = rd;
      @(posedge clk);
      @(negedge clk);
      burst_rdy = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int relCount;
      int relAt;
      logic [7:0] relSeen;

      clk = 1'b0;
      rst = 1'b1;
      burst = '0;
      burst_rdy = 1'b0;
      cmd_ready = 1'b1;

      vecs[0] = '{F01,     1'b1, 1'b0, 1'b1, 8'h01, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{F01_BAD, 1'b1, 1'b1, 1'b0, 8'h01, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01};
      vecs[2] = '{F20,     1'b1, 1'b1, 1'b0, 8'h01, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01};
      vecs[3] = '{F01,     1'b1, 1'b0, 1'b1, 8'h01, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01};
      vecs[4] = '{32'h0,   1'b0, 1'b1, 1'b0, 8'h01, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01};
      vecs[5] = '{F02,     1'b1, 1'b0, 1'b1, 8'h02, 8'h10, 1'b0, 1'b1, 8'h01, 1'b0, 8'h01};
      vecs[6] = '{F03,     1'b1, 1'b0, 1'b1, 8'h02, 8'h10, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01};
      vecs[7] = '{F03,     1'b1, 1'b1, 1'b1, 8'h03, 8'h10, 1'b1, 1'b0, 8'h02, 1'b1, 8'h01};
      vecs[8] = '{32'h0,   1'b0, 1'b1, 1'b0, 8'h03, 8'h10, 1'b1, 1'b0, 8'h02, 1'b1, 8'h01};
      vecs[9] = '{F07,     1'b0, 1'b1, 1'b0, 8'h03, 8'h10, 1'b1, 1'b0, 8'h02, 1'b1, 8'h01};

      @(negedge clk);
      checkOutput("reset cmd_valid", 32'(cmd_valid), 32'h0);
      checkOutput("reset err_count", 32'(err_count), 32'h0);
      checkOutput("reset key_release", 32'(key_release), 32'h0);
      checkOutput("reset overflow", 32'(overflow), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].burst, vecs[i].rdy, vecs[i].ready);
         checkOutput($sformatf("vec%0d cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d cmd", i), 32'(cmd), 32'(vecs[i].expCmd));
         checkOutput($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].expAddr));
         checkOutput($sformatf("vec%0d is_repeat", i), 32'(is_repeat), 32'(vecs[i].expRepeat));
         checkOutput($sformatf("vec%0d key_release", i), 32'(key_release), 32'(vecs[i].expRelease));
         checkOutput($sformatf("vec%0d rel_cmd", i), 32'(rel_cmd), 32'(vecs[i].expRel));
         checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].expErr));
      end

      // Error counter saturation
      doReset();
      applyStimulus(F01_BAD, 1'b1, 1'b1);
      checkOutput("err first", 32'(err_count), 32'd1);
      for (int i = 0; i < 299; i++) begin
         applyStimulus(F01_BAD, 1'b1, 1'b1);
         applyStimulus(32'h0, 1'b0, 1'b1);
      end
      checkOutput("err saturated", 32'(err_count), 32'd255);
      checkOutput("err no valid", 32'(cmd_valid), 32'h0);

      // Repeat within window, then expiry after exactly HOLD_CYCLES idle cycles
      doReset();
      applyStimulus(F01, 1'b1, 1'b1);
      checkOutput("hold first repeat", 32'(is_repeat), 32'h0);
      repeat (50) applyStimulus(32'h0, 1'b0, 1'b1);
      applyStimulus(F01, 1'b1, 1'b1);
      checkOutput("hold second valid", 32'(cmd_valid), 32'h1);
      checkOutput("hold second repeat", 32'(is_repeat), 32'h1);
      relCount = 0;
      relAt = 0;
      relSeen = 8'h00;
      for (int k = 1; k <= 110; k++) begin
         applyStimulus(32'h0, 1'b0, 1'b1);
         if (key_release) begin
            relCount++;
            relAt = k;
            relSeen = rel_cmd;
         end
      end
      checkOutput("expiry release count", 32'(relCount), 32'd1);
      checkOutput("expiry release cycle", 32'(relAt), 32'd100);
      checkOutput("expiry rel_cmd", 32'(relSeen), 32'h01);
      applyStimulus(F01, 1'b1, 1'b1);
      checkOutput("after expiry repeat", 32'(is_repeat), 32'h0);

      // Frame arriving exactly as the timer would expire wins
      relCount = 0;
      for (int k = 1; k <= 99; k++) begin
         applyStimulus(32'h0, 1'b0, 1'b1);
         if (key_release) relCount++;
      end
      applyStimulus(F01, 1'b1, 1'b1);
      checkOutput("edge release count", 32'(relCount), 32'd0);
      checkOutput("edge key_release", 32'(key_release), 32'h0);
      checkOutput("edge repeat", 32'(is_repeat), 32'h1);
      relCount = 0;
      relAt = 0;
      for (int k = 1; k <= 105; k++) begin
         applyStimulus(32'h0, 1'b0, 1'b1);
         if (key_release) begin
            relCount++;
            relAt = k;
         end
      end
      checkOutput("edge reload count", 32'(relCount), 32'd1);
      checkOutput("edge reload cycle", 32'(relAt), 32'd100);

      // Reset during HELD discards the key silently
      applyStimulus(F05, 1'b1, 1'b0);
      repeat (10) applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("pre-reset valid", 32'(cmd_valid), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("midrst cmd_valid", 32'(cmd_valid), 32'h0);
      checkOutput("midrst cmd", 32'(cmd), 32'h0);
      checkOutput("midrst addr", 32'(addr), 32'h0);
      checkOutput("midrst is_repeat", 32'(is_repeat), 32'h0);
      checkOutput("midrst key_release", 32'(key_release), 32'h0);
      checkOutput("midrst rel_cmd", 32'(rel_cmd), 32'h0);
      checkOutput("midrst overflow", 32'(overflow), 32'h0);
      checkOutput("midrst err_count", 32'(err_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      relCount = 0;
      for (int k = 1; k <= 150; k++) begin
         applyStimulus(32'h0, 1'b0, 1'b1);
         if (key_release) relCount++;
      end
      checkOutput("midrst no release", 32'(relCount), 32'd0);
      applyStimulus(F05, 1'b1, 1'b1);
      checkOutput("midrst new repeat", 32'(is_repeat), 32'h0);
      checkOutput("midrst new cmd", 32'(cmd), 32'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ir_frame_decode.md
IR_FRAME_DECODE -- requirements
Module: ir_frame_decode

Interface
REQ-001 The block SHALL have parameter ADDR_MATCH, default 8'h10, the address byte accepted when filtering is on.
REQ-002 The block SHALL have parameter FILTER_EN, default 1, where 1 enables address filtering.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 12_000_000 (120 ms at 100 MHz), the key-hold window in clk cycles.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port burst, input, 32: raw received frame from the IR receiver.
REQ-007 Port burst_rdy, input, 1: one-cycle pulse; burst valid in that cycle.
REQ-008 Port cmd_valid, output, 1: decoded command available.
REQ-009 Port cmd_ready, input, 1: consumer accepts the command.
REQ-010 Port cmd, output, 8: decoded command byte.
REQ-011 Port addr, output, 8: decoded address byte.
REQ-012 Port is_repeat, output, 1: the held command is a repeat of the previous key.
REQ-013 Port key_release, output, 1: one-cycle pulse when the held key ends.
REQ-014 Port rel_cmd, output, 8: command being released; valid with key_release.
REQ-015 Port err_count, output, 8: count of frames failing the inverse check; saturates at 255.
REQ-016 Port overflow, output, 1: sticky; a valid frame was dropped because the output was full.

Function
REQ-017 Frame layout SHALL be burst[31:24]=addr, [23:16]=~addr, [15:8]=cmd, [7:0]=~cmd.
REQ-018 Frames SHALL be sampled only in cycles where burst_rdy=1; all other cycles SHALL leave burst ignored.
REQ-019 A frame SHALL be valid only when both inverse bytes are the exact bitwise complements.
REQ-020 An invalid frame SHALL increment err_count by 1 (saturating) and SHALL NOT affect the hold state or the output.
REQ-021 With FILTER_EN=1 and addr!=ADDR_MATCH, a valid frame SHALL be dropped silently: no error, no hold-state change.
REQ-022 The hold FSM SHALL have states IDLE and HELD, and SHALL store last_cmd plus a hold timer of width $clog2(HOLD_CYCLES+1).
REQ-023 An accepted frame received in IDLE SHALL be presented with is_repeat=0, and the FSM SHALL go to HELD with timer=HOLD_CYCLES and last_cmd=cmd.
REQ-024 An accepted frame in HELD with cmd==last_cmd SHALL be presented with is_repeat=1 and SHALL reload the timer.
REQ-025 An accepted frame in HELD with cmd!=last_cmd SHALL pulse key_release with rel_cmd=old last_cmd in that cycle, present the new frame with is_repeat=0, and reload the timer and last_cmd.
REQ-026 In HELD with no frame, the timer SHALL decrement each cycle; on reaching 0 it SHALL pulse key_release with rel_cmd=last_cmd and return to IDLE.
REQ-027 If a frame is accepted in the same cycle the timer would reach 0, the frame SHALL take priority: the timer is reloaded and there is no expiry release.
REQ-028 The output SHALL be a single-entry buffer: cmd_valid rises one cycle after burst_rdy (latency 1), with cmd, addr and is_repeat held stable while cmd_valid=1.
REQ-029 A transfer SHALL occur on a cycle where cmd_valid=1 and cmd_ready=1, and cmd_valid SHALL fall the next cycle unless a new frame loads in that same cycle.
REQ-030 A frame arriving while the buffer is full and not draining SHALL be dropped and set overflow; the hold FSM SHALL still update.
REQ-031 A frame arriving in the same cycle the buffer drains SHALL load into the buffer, with no overflow.
REQ-032 key_release SHALL be independent of the cmd_valid/cmd_ready handshake and SHALL NOT be back-pressured.

Reset
REQ-033 On rst, cmd_valid, is_repeat, key_release, overflow, err_count, cmd, addr, rel_cmd, the timer and last_cmd SHALL all be 0, and the FSM SHALL be IDLE.
REQ-034 rst asserted mid-hold SHALL discard the held key without producing a key_release pulse.

Structure
REQ-035 Frame field offsets, the IDLE/HELD encoding and the default ADDR_MATCH SHALL live in a shared ir_pkg package, also used by the IR transmitter.
REQ-036 The frame check SHALL be one sub-module, ir_frame_check, taking burst[31:0] and producing ok, addr and cmd.

Verification
REQ-037 Bench: burst=32'h10EF01FE pulse -> next cycle cmd_valid=1, cmd=01, addr=10, is_repeat=0; err_count=0.
REQ-038 Bench: burst=32'h10EF01FF -> err_count=1 and no cmd_valid; repeat 300 invalid frames -> err_count=255.
REQ-039 Bench: HOLD_CYCLES=100; frame 01, then frame 01 after 50 cycles -> second output has is_repeat=1; idle 101 cycles -> one key_release pulse with rel_cmd=01.
REQ-040 Bench: HOLD_CYCLES=100; frame 01 then frame 02 within the window -> key_release pulse with rel_cmd=01 in the same cycle that frame 02 is accepted; frame 02 output has is_repeat=0.
REQ-041 Bench: cmd_ready=0; two valid frames -> first is retained and overflow=1; then a frame with cmd_ready=1 in the same cycle -> new frame loaded, no further drop.
REQ-042 Bench: addr=8'h20 frame with FILTER_EN=1 -> no output and no error; rst asserted during HELD -> all outputs 0 and no key_release pulse.
